// File: rtl/udp_panel_dispatch.sv
// -----------------------------------------------------------------------------
// udp_panel_dispatch
// Turns UDP payload words from the liteeth udp_source stream into framebuffer
// writes on the ledpanel ctrl bus for NUM_PANELS panels. Supports per-panel or
// broadcast WRITE, hardware FILL, an LED command, port filtering and dropping
// of corrupt or unknown packets.
//
// Optional build macro: PANEL_DISPATCH_STATS_EN adds pkt_count / drop_count.
//
// Ports:
//   clock, resetn              system clock, async active-low reset
//   udp_source_valid/last      payload word handshake and end-of-packet
//   udp_source_ready           word accepted when valid & ready
//   udp_source_dst_port        destination port, checked with the header word
//   udp_source_data            32-bit payload word
//   udp_source_error           nonzero marks a corrupt word
//   ctrl_en                    per-panel write strobe (one-hot or all ones)
//   ctrl_wr                    colour-plane mask
//   ctrl_addr, ctrl_wdat       write address and data
//   pkt_count, drop_count      (stats build only) saturating packet counters
//   led_reg                    user LED
// -----------------------------------------------------------------------------
module udp_panel_dispatch #(
  parameter int unsigned NUM_PANELS = 6,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned COLOR_W    = 24,
  parameter logic [15:0] UDP_PORT   = 16'd26177
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  udp_source_valid,
  input  logic                  udp_source_last,
  output logic                  udp_source_ready,
  input  logic [15:0]           udp_source_dst_port,
  input  logic [31:0]           udp_source_data,
  input  logic [3:0]            udp_source_error,
  output logic [NUM_PANELS-1:0] ctrl_en,
  output logic [3:0]            ctrl_wr,
  output logic [ADDR_W-1:0]     ctrl_addr,
  output logic [COLOR_W-1:0]    ctrl_wdat,
`ifdef PANEL_DISPATCH_STATS_EN
  output logic [15:0]           pkt_count,
  output logic [15:0]           drop_count,
`endif
  output logic                  led_reg
);

  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_FILL  = 4'd2;
  localparam logic [3:0] OP_LED   = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_FILL_CNT,
    S_FILL_COL,
    S_FILL_RUN,
    S_DROP
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic [NUM_PANELS-1:0] r_ctrl_en;
  logic [3:0]            r_ctrl_wr;
  logic [ADDR_W-1:0]     r_ctrl_addr;
  logic [COLOR_W-1:0]    r_ctrl_wdat;
  logic                  r_led;
  logic [NUM_PANELS-1:0] r_en_vec;
  logic [3:0]            r_mask;
  logic [ADDR_W-1:0]     r_addr;
  logic [COLOR_W-1:0]    r_color;
  logic [15:0]           r_count;
  logic                  r_fill_drop;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_err;
  logic [3:0]            w_op;
  logic [7:0]            w_idx;
  logic                  w_bcast;
  logic                  w_idx_ok;
  logic                  w_op_ok;
  logic                  w_hdr_drop;
  logic [NUM_PANELS-1:0] w_en_vec;

  // Header decode; only meaningful while in IDLE.
  assign w_accept   = udp_source_valid & r_ready;
  assign w_last     = udp_source_last;
  assign w_err      = |udp_source_error;
  assign w_op       = udp_source_data[31:28];
  assign w_idx      = udp_source_data[23:16];
  assign w_bcast    = (w_idx == 8'hFF);
  assign w_idx_ok   = w_bcast || (32'(w_idx) < NUM_PANELS);
  assign w_op_ok    = (w_op == OP_WRITE) || (w_op == OP_FILL) || (w_op == OP_LED);
  assign w_hdr_drop = (udp_source_dst_port != UDP_PORT) || w_err || !w_op_ok || !w_idx_ok;

  // Panel enable vector: all ones for broadcast, otherwise one-hot.
  always_comb begin
    w_en_vec = '0;
    for (int unsigned i = 0; i < NUM_PANELS; i++) begin
      w_en_vec[i] = w_bcast || (w_idx == 8'(i));
    end
  end

  // Packet FSM with registered ctrl outputs; ctrl_en defaults low every cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_ctrl_en   <= '0;
      r_ctrl_wr   <= '0;
      r_ctrl_addr <= '0;
      r_ctrl_wdat <= '0;
      r_led       <= 1'b0;
      r_en_vec    <= '0;
      r_mask      <= '0;
      r_addr      <= '0;
      r_color     <= '0;
      r_count     <= '0;
      r_fill_drop <= 1'b0;
    end else begin
      r_ctrl_en <= '0;
      r_ready   <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_hdr_drop) begin
              r_state <= w_last ? S_IDLE : S_DROP;
            end else if (w_op == OP_LED) begin
              r_led   <= udp_source_data[0];
              r_state <= w_last ? S_IDLE : S_DROP;
            end else begin
              r_mask   <= udp_source_data[27:24];
              r_en_vec <= w_en_vec;
              r_addr   <= ADDR_W'(udp_source_data[15:0]);
              if (w_last)                r_state <= S_IDLE;
              else if (w_op == OP_WRITE) r_state <= S_WRITE;
              else                       r_state <= S_FILL_CNT;
            end
          end
        end

        S_WRITE: begin
          if (w_accept) begin
            if (w_err) begin
              r_state <= w_last ? S_IDLE : S_DROP;
            end else begin
              r_ctrl_en   <= r_en_vec;
              r_ctrl_wr   <= r_mask;
              r_ctrl_addr <= r_addr;
              r_ctrl_wdat <= udp_source_data[COLOR_W-1:0];
              r_addr      <= r_addr + ADDR_W'(1);
              if (w_last) r_state <= S_IDLE;
            end
          end
        end

        S_FILL_CNT: begin
          if (w_accept) begin
            if (w_err) begin
              r_state <= w_last ? S_IDLE : S_DROP;
            end else begin
              r_count <= udp_source_data[15:0];
              r_state <= w_last ? S_IDLE : S_FILL_COL;
            end
          end
        end

        S_FILL_COL: begin
          if (w_accept) begin
            if (w_err) begin
              r_state <= w_last ? S_IDLE : S_DROP;
            end else begin
              r_color     <= udp_source_data[COLOR_W-1:0];
              r_fill_drop <= !w_last;
              // A zero count skips the run so ready never drops.
              if (r_count == 16'd0) begin
                r_state <= w_last ? S_IDLE : S_DROP;
              end else begin
                r_state <= S_FILL_RUN;
                r_ready <= 1'b0;
              end
            end
          end
        end

        S_FILL_RUN: begin
          r_ctrl_en   <= r_en_vec;
          r_ctrl_wr   <= r_mask;
          r_ctrl_addr <= r_addr;
          r_ctrl_wdat <= r_color;
          r_addr      <= r_addr + ADDR_W'(1);
          r_count     <= r_count - 16'd1;
          if (r_count == 16'd1) begin
            r_state <= r_fill_drop ? S_DROP : S_IDLE;
          end else begin
            r_ready <= 1'b0;
          end
        end

        S_DROP: begin
          if (w_accept && w_last) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign udp_source_ready = r_ready;
  assign ctrl_en          = r_ctrl_en;
  assign ctrl_wr          = r_ctrl_wr;
  assign ctrl_addr        = r_ctrl_addr;
  assign ctrl_wdat        = r_ctrl_wdat;
  assign led_reg          = r_led;

`ifdef PANEL_DISPATCH_STATS_EN
  logic        w_pkt_evt;
  logic        w_drop_evt;
  logic [15:0] r_pkt_count;
  logic [15:0] r_drop_count;

  // Completed command packets and drop events (DROP entry or dropped single word).
  always_comb begin
    w_pkt_evt  = 1'b0;
    w_drop_evt = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          w_drop_evt = w_hdr_drop || (w_op == OP_LED && !w_last);
          w_pkt_evt  = !w_hdr_drop && ((w_op == OP_LED) || w_last);
        end
        S_WRITE: begin
          w_drop_evt = w_err && !w_last;
          w_pkt_evt  = !w_err && w_last;
        end
        S_FILL_CNT: w_drop_evt = w_err && !w_last;
        S_FILL_COL: begin
          w_drop_evt = !w_last && (w_err || r_count == 16'd0);
          w_pkt_evt  = !w_err;
        end
        default: ;
      endcase
    end
    if (r_state == S_FILL_RUN && r_count == 16'd1 && r_fill_drop) w_drop_evt = 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_pkt_evt && r_pkt_count != 16'hFFFF)   r_pkt_count  <= r_pkt_count + 16'd1;
      if (w_drop_evt && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_udp_panel_dispatch.sv
// -----------------------------------------------------------------------------
// tb_udp_panel_dispatch
// Directed packets against udp_panel_dispatch. A packet-level model predicts the
// write sequence and LED state; a monitor compares every write strobe against
// it, and literal expectations pin the model for the key scenarios.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_udp_panel_dispatch;

  localparam int unsigned NP   = 6;
  localparam logic [15:0] PORT = 16'd26177;

  typedef struct packed {
    logic [5:0]  en;
    logic [3:0]  wr;
    logic [15:0] addr;
    logic [23:0] wdat;
  } wr_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        udp_source_valid;
  logic        udp_source_last;
  logic        udp_source_ready;
  logic [15:0] udp_source_dst_port;
  logic [31:0] udp_source_data;
  logic [3:0]  udp_source_error;
  logic [5:0]  ctrl_en;
  logic [3:0]  ctrl_wr;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic        led_reg;

  udp_panel_dispatch dut (
    .clock               (clock),
    .resetn              (resetn),
    .udp_source_valid    (udp_source_valid),
    .udp_source_last     (udp_source_last),
    .udp_source_ready    (udp_source_ready),
    .udp_source_dst_port (udp_source_dst_port),
    .udp_source_data     (udp_source_data),
    .udp_source_error    (udp_source_error),
    .ctrl_en             (ctrl_en),
    .ctrl_wr             (ctrl_wr),
    .ctrl_addr           (ctrl_addr),
    .ctrl_wdat           (ctrl_wdat),
    .led_reg             (led_reg)
  );

  always #5 clock = ~clock;

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  int          low_cnt = 0;
  wr_t         exp_q[$];
  wr_t         obs_q[$];
  int          obs_cyc[$];
  logic        m_led = 1'b0;
  logic [31:0] pk_data[$];
  logic [3:0]  pk_err[$];
  wr_t         mon_got;
  wr_t         mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  function automatic wr_t get_obs(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return '0;
  endfunction

  // Packet-level model: expected writes follow directly from the header fields.
  task automatic model_pkt(input logic [15:0] port);
    logic [31:0] h;
    logic [31:0] tmp;
    logic [3:0]  op;
    logic [7:0]  idx;
    logic [5:0]  en;
    logic [15:0] a;
    logic [15:0] cnt;
    wr_t         w;
    h   = pk_data[0];
    op  = h[31:28];
    idx = h[23:16];
    if (port != PORT || pk_err[0] != 4'd0) return;
    if (op != 4'd1 && op != 4'd2 && op != 4'd3) return;
    if (idx != 8'hFF && idx >= 8'(NP)) return;
    en = (idx == 8'hFF) ? 6'h3F : (6'(1) << idx);
    a  = h[15:0];
    if (op == 4'd3) begin
      m_led = h[0];
      return;
    end
    if (op == 4'd1) begin
      for (int i = 1; i < pk_data.size(); i++) begin
        if (pk_err[i] != 4'd0) break;
        tmp    = pk_data[i];
        w.en   = en;
        w.wr   = h[27:24];
        w.addr = a;
        w.wdat = tmp[23:0];
        exp_q.push_back(w);
        a = a + 16'd1;
      end
    end else if (pk_data.size() >= 3 && pk_err[1] == 4'd0 && pk_err[2] == 4'd0) begin
      tmp = pk_data[1];
      cnt = tmp[15:0];
      tmp = pk_data[2];
      for (int k = 0; k < int'(cnt); k++) begin
        w.en   = en;
        w.wr   = h[27:24];
        w.addr = a;
        w.wdat = tmp[23:0];
        exp_q.push_back(w);
        a = a + 16'd1;
      end
    end
  endtask

  // Drives the current packet word by word; called and returns on a negedge.
  task automatic send_pkt(input logic [15:0] port);
    int n;
    model_pkt(port);
    for (int i = 0; i < pk_data.size(); i++) begin
      udp_source_valid    = 1'b1;
      udp_source_dst_port = port;
      udp_source_data     = pk_data[i];
      udp_source_error    = pk_err[i];
      udp_source_last     = (i == pk_data.size() - 1);
      n = 0;
      while (!udp_source_ready && n < 300) begin
        @(negedge clock);
        n++;
      end
      if (n >= 300) check("ready_timeout", 64'(udp_source_ready), 64'(1));
      @(negedge clock);
    end
    udp_source_valid = 1'b0;
    udp_source_last  = 1'b0;
    udp_source_error = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every write strobe must match the next model write, in order.
  always @(negedge clock) begin
    if (resetn && !udp_source_ready) low_cnt++;
    if (resetn && ctrl_en != 6'd0) begin
      mon_got = {ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat};
      obs_q.push_back(mon_got);
      obs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(mon_got), 64'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check("write", 64'(mon_got), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    resetn              = 1'b0;
    udp_source_valid    = 1'b0;
    udp_source_last     = 1'b0;
    udp_source_dst_port = 16'd0;
    udp_source_data     = 32'd0;
    udp_source_error    = 4'd0;
    idle(3);
    check("rst_ready", 64'(udp_source_ready), 64'(0));
    check("rst_en",    64'(ctrl_en),   64'(0));
    check("rst_wr",    64'(ctrl_wr),   64'(0));
    check("rst_addr",  64'(ctrl_addr), 64'(0));
    check("rst_wdat",  64'(ctrl_wdat), 64'(0));
    check("rst_led",   64'(led_reg),   64'(0));
    #2 resetn = 1'b1;
    #1 check("ready_first_cycle", 64'(udp_source_ready), 64'(0));
    @(negedge clock);
    check("ready_after_first", 64'(udp_source_ready), 64'(1));

    // Single-panel WRITE of two words.
    clear_obs();
    pk_data = '{32'h1F020010, 32'h00AABBCC, 32'h00112233};
    pk_err  = '{4'd0, 4'd0, 4'd0};
    send_pkt(PORT);
    idle(3);
    check("t1_count", 64'(obs_q.size()), 64'(2));
    check("t1_w0", 64'(get_obs(0)), 64'({6'b000100, 4'hF, 16'h0010, 24'hAABBCC}));
    check("t1_w1", 64'(get_obs(1)), 64'({6'b000100, 4'hF, 16'h0011, 24'h112233}));
    if (obs_cyc.size() == 2) check("t1_consecutive", 64'(obs_cyc[1] - obs_cyc[0]), 64'(1));

    // Broadcast FILL wrapping the address space.
    clear_obs();
    low_cnt = 0;
    pk_data = '{32'h21FFFFFE, 32'h00000003, 32'h00FF0000};
    pk_err  = '{4'd0, 4'd0, 4'd0};
    send_pkt(PORT);
    idle(6);
    check("t2_ready_low", 64'(low_cnt), 64'(3));
    check("t2_count", 64'(obs_q.size()), 64'(3));
    check("t2_w0", 64'(get_obs(0)), 64'({6'h3F, 4'h1, 16'hFFFE, 24'hFF0000}));
    check("t2_w1", 64'(get_obs(1)), 64'({6'h3F, 4'h1, 16'hFFFF, 24'hFF0000}));
    check("t2_w2", 64'(get_obs(2)), 64'({6'h3F, 4'h1, 16'h0000, 24'hFF0000}));

    // Wrong destination port, then a normal packet.
    clear_obs();
    pk_data = '{32'h1F000000, 32'h00000001, 32'h00000002, 32'h00000003};
    pk_err  = '{4'd0, 4'd0, 4'd0, 4'd0};
    send_pkt(16'd1234);
    idle(3);
    check("t3_no_write", 64'(obs_q.size()), 64'(0));
    pk_data = '{32'h13000005, 32'h0000CAFE};
    pk_err  = '{4'd0, 4'd0};
    send_pkt(PORT);
    idle(3);
    check("t3_count", 64'(obs_q.size()), 64'(1));
    check("t3_w0", 64'(get_obs(0)), 64'({6'b000001, 4'h3, 16'h0005, 24'h00CAFE}));

    // Error on the second data word of a WRITE.
    clear_obs();
    pk_data = '{32'h1F010020, 32'h00000111, 32'h00000222, 32'h00000333};
    pk_err  = '{4'd0, 4'd0, 4'd1, 4'd0};
    send_pkt(PORT);
    idle(3);
    check("t4_count", 64'(obs_q.size()), 64'(1));
    check("t4_w0", 64'(get_obs(0)), 64'({6'b000010, 4'hF, 16'h0020, 24'h000111}));

    // LED command, out-of-range index, broadcast LED off.
    pk_data = '{32'h30000001};
    pk_err  = '{4'd0};
    send_pkt(PORT);
    idle(2);
    check("t5_led_on", 64'(led_reg), 64'(1));
    pk_data = '{32'h30070000};
    send_pkt(PORT);
    idle(2);
    check("t5_led_bad_idx", 64'(led_reg), 64'(1));
    check("t5_led_model", 64'(led_reg), 64'(m_led));
    pk_data = '{32'h30FF0000};
    send_pkt(PORT);
    idle(2);
    check("t5_led_off", 64'(led_reg), 64'(0));

    // Unknown opcode, zero-count FILL, FILL followed by trailing words.
    clear_obs();
    pk_data = '{32'h5F000000, 32'h00000001};
    pk_err  = '{4'd0, 4'd0};
    send_pkt(PORT);
    pk_data = '{32'h2F000000, 32'h00000000, 32'h000000FF};
    pk_err  = '{4'd0, 4'd0, 4'd0};
    send_pkt(PORT);
    idle(3);
    check("t7_no_write", 64'(obs_q.size()), 64'(0));
    pk_data = '{32'h24030100, 32'h00000002, 32'h00000A0B, 32'h00000099};
    pk_err  = '{4'd0, 4'd0, 4'd0, 4'd0};
    send_pkt(PORT);
    idle(4);
    check("t7_count", 64'(obs_q.size()), 64'(2));
    check("t7_w1", 64'(get_obs(1)), 64'({6'b001000, 4'h4, 16'h0101, 24'h000A0B}));

    // Reset in the middle of a long FILL run.
    clear_obs();
    pk_data = '{32'h2F000000, 32'h00000064, 32'h00ABCDEF};
    pk_err  = '{4'd0, 4'd0, 4'd0};
    send_pkt(PORT);
    idle(10);
    #1 check("t6_run_writes", 64'(obs_q.size()), 64'(10));
    #1 resetn = 1'b0;
    #1 check("t6_rst_en", 64'(ctrl_en), 64'(0));
    check("t6_rst_ready", 64'(udp_source_ready), 64'(0));
    exp_q.delete();
    idle(2);
    #2 resetn = 1'b1;
    @(negedge clock);
    clear_obs();
    pk_data = '{32'h1F050040, 32'h00123456};
    pk_err  = '{4'd0, 4'd0};
    send_pkt(PORT);
    idle(3);
    check("t6_count", 64'(obs_q.size()), 64'(1));
    check("t6_w0", 64'(get_obs(0)), 64'({6'b100000, 4'hF, 16'h0040, 24'h123456}));

    check("exp_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
